leaf_credit_tx: RTL and testbench



---
 rtl/leaf_credit_tx_if.sv | 25 ++
 rtl/leaf_credit_tx.sv | 91 +++++++++
 tb/tb_leaf_credit_tx.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/leaf_credit_tx_if.sv
// rtl/leaf_credit_tx_if.sv - word stream and pi-switch packet ports of the leaf credit transmitter
interface leaf_credit_tx_if #(
  parameter int PAYLOAD_W = 32,
  parameter int ADDR_W    = 5,
  parameter int PORT_W    = 4
);
  localparam int PKT_W = 1 + ADDR_W + PORT_W + PAYLOAD_W;

  logic [PAYLOAD_W-1:0] din;
  logic                 din_valid;
  logic                 din_ready;
  logic [PKT_W-1:0]     pkt_out;
  logic [PKT_W-1:0]     pkt_in;
  logic [PKT_W-1:0]     rx_pkt;

  modport slave (
    input  din, din_valid, pkt_in,
    output din_ready, pkt_out, rx_pkt
  );

  modport master (
    output din, din_valid, pkt_in,
    input  din_ready, pkt_out, rx_pkt
  );
endinterface

// File: rtl/leaf_credit_tx.sv
// rtl/leaf_credit_tx.sv - leaf uplink packetizer with credit flow control
// Credit-return packets on the downlink are consumed; everything else is forwarded to rx_pkt.
module leaf_credit_tx #(
  parameter int                PAYLOAD_W    = 32,
  parameter int                ADDR_W       = 5,
  parameter int                PORT_W       = 4,
  parameter int                CRED_W       = 6,
  parameter int                INIT_CREDITS = 16,
  parameter logic [PORT_W-1:0] CRED_PORT    = 4'hF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_load,
  input  logic [ADDR_W-1:0]   cfg_addr,
  input  logic [PORT_W-1:0]   cfg_port,
  leaf_credit_tx_if.slave     bus,
  output logic [CRED_W-1:0]   credits,
  output logic                cred_err,
  output logic [15:0]         tx_count
);
  localparam int PKT_W = 1 + ADDR_W + PORT_W + PAYLOAD_W;
  localparam logic [CRED_W:0]   INIT_SUM  = (CRED_W+1)'(INIT_CREDITS);
  localparam logic [CRED_W-1:0] INIT_CRED = CRED_W'(INIT_CREDITS);

  typedef enum logic [1:0] {UNCFG, RUN, STALL} state_t;

  state_t              state_q, state_next;
  logic [CRED_W-1:0]   credits_q, cred_next, ret_amt;
  logic [CRED_W:0]     cred_sum;
  logic                cred_err_q, overflow, send, is_credit, ready;
  logic [15:0]         tx_count_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [PORT_W-1:0]   port_q;
  logic [PKT_W-1:0]    pkt_out_q, rx_pkt_q;

  assign ready         = (state_q == RUN) && (credits_q != '0);
  assign bus.din_ready = ready;
  assign bus.pkt_out   = pkt_out_q;
  assign bus.rx_pkt    = rx_pkt_q;
  assign credits       = credits_q;
  assign cred_err      = cred_err_q;
  assign tx_count      = tx_count_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= UNCFG;
    else       state_q <= state_next;
  end

  // The state tracks the credit count one cycle ahead so din_ready reopens right after a return.
  always_comb begin
    send       = bus.din_valid && ready;
    is_credit  = bus.pkt_in[PKT_W-1] && (bus.pkt_in[PAYLOAD_W +: PORT_W] == CRED_PORT);
    ret_amt    = is_credit ? bus.pkt_in[CRED_W-1:0] : '0;
    cred_sum   = {1'b0, credits_q} - (CRED_W+1)'(send) + {1'b0, ret_amt};
    overflow   = cred_sum > INIT_SUM;
    cred_next  = overflow ? INIT_CRED : cred_sum[CRED_W-1:0];
    state_next = state_q;
    case (state_q)
      UNCFG:   state_next = UNCFG;
      RUN:     if (cred_next == '0) state_next = STALL;
      STALL:   if (cred_next != '0) state_next = RUN;
      default: state_next = UNCFG;
    endcase
    if (cfg_load) state_next = RUN;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      credits_q  <= INIT_CRED;
      cred_err_q <= 1'b0;
      tx_count_q <= '0;
      addr_q     <= '0;
      port_q     <= '0;
      pkt_out_q  <= '0;
      rx_pkt_q   <= '0;
    end else begin
      pkt_out_q <= send ? {1'b1, addr_q, port_q, bus.din} : '0;
      rx_pkt_q  <= is_credit ? '0 : bus.pkt_in;
      if (send) tx_count_q <= tx_count_q + 16'd1;
      if (cfg_load) begin
        addr_q     <= cfg_addr;
        port_q     <= cfg_port;
        credits_q  <= INIT_CRED;
        cred_err_q <= 1'b0;
      end else if (state_q != UNCFG) begin
        credits_q <= cred_next;
        if (overflow) cred_err_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_leaf_credit_tx.sv
// tb/tb_leaf_credit_tx.sv - directed vector bench for leaf_credit_tx
module tb_leaf_credit_tx;
  localparam int PAYLOAD_W = 32;
  localparam int ADDR_W    = 5;
  localparam int PORT_W    = 4;
  localparam int CRED_W    = 6;
  localparam int PKT_W     = 1 + ADDR_W + PORT_W + PAYLOAD_W;

  typedef struct {
    logic              cfg;
    logic              valid;
    logic [31:0]       data;
    logic [PKT_W-1:0]  pin;
    logic              e_ready;
    logic [PKT_W-1:0]  e_pout;
    logic [PKT_W-1:0]  e_rx;
    logic [CRED_W-1:0] e_cred;
    logic              e_err;
    logic [15:0]       e_tx;
  } vec_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cfg_load = 1'b0;
  logic [ADDR_W-1:0] cfg_addr = '0;
  logic [PORT_W-1:0] cfg_port = '0;
  logic [CRED_W-1:0] credits;
  logic              cred_err;
  logic [15:0]       tx_count;
  int                checks = 0;
  int                errors = 0;
  vec_t              vecs[$];

  leaf_credit_tx_if #(.PAYLOAD_W(PAYLOAD_W), .ADDR_W(ADDR_W), .PORT_W(PORT_W)) bus ();

  leaf_credit_tx dut (
    .clk      (clk),
    .reset    (reset),
    .cfg_load (cfg_load),
    .cfg_addr (cfg_addr),
    .cfg_port (cfg_port),
    .bus      (bus),
    .credits  (credits),
    .cred_err (cred_err),
    .tx_count (tx_count)
  );

  always #5 clk = ~clk;

  function automatic logic [PKT_W-1:0] mk(input logic v, input logic [4:0] a,
                                          input logic [3:0] p, input logic [31:0] d);
    return {v, a, p, d};
  endfunction

  function automatic logic [PKT_W-1:0] cred(input logic [31:0] n);
    return mk(1'b1, 5'h00, 4'hF, n);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int sent;
    bus.din       = '0;
    bus.din_valid = 1'b0;
    bus.pkt_in    = '0;

    step();
    step();
    reset = 1'b0;
    chk("reset din_ready", bus.din_ready, 0);
    chk("reset pkt_out",   bus.pkt_out,   0);
    chk("reset rx_pkt",    bus.rx_pkt,    0);
    chk("reset credits",   credits,       16);
    chk("reset cred_err",  cred_err,      0);
    chk("reset tx_count",  tx_count,      0);

    // Unconfigured: stream is held off and credit returns are ignored
    for (int i = 0; i < 10; i++) begin
      bus.din_valid = 1'b1;
      bus.din       = 32'h100 + i;
      bus.pkt_in    = (i == 3) ? cred(32'd1) : '0;
      step();
      chk($sformatf("uncfg%0d din_ready", i), bus.din_ready, 0);
      chk($sformatf("uncfg%0d pkt_out", i),   bus.pkt_out,   0);
      chk($sformatf("uncfg%0d credits", i),   credits,       16);
      chk($sformatf("uncfg%0d cred_err", i),  cred_err,      0);
      chk($sformatf("uncfg%0d rx_pkt", i),    bus.rx_pkt,    0);
    end
    bus.pkt_in = '0;

    vecs.push_back('{1'b1, 1'b0, 32'h0,        '0,                              1'b1, '0,                              '0,                              6'd16, 1'b0, 16'd0});
    vecs.push_back('{1'b0, 1'b1, 32'hA5A50001, '0,                              1'b1, mk(1, 5'h03, 4'h2, 32'hA5A50001), '0,                              6'd15, 1'b0, 16'd1});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        mk(1, 5'h07, 4'h1, 32'hDEADBEEF), 1'b1, '0,                              mk(1, 5'h07, 4'h1, 32'hDEADBEEF), 6'd15, 1'b0, 16'd1});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        cred(32'd5),                     1'b1, '0,                              '0,                              6'd16, 1'b1, 16'd1});
    vecs.push_back('{1'b0, 1'b1, 32'h11111111, '0,                              1'b1, mk(1, 5'h03, 4'h2, 32'h11111111), '0,                              6'd15, 1'b1, 16'd2});
    vecs.push_back('{1'b1, 1'b0, 32'h0,        '0,                              1'b1, '0,                              '0,                              6'd16, 1'b0, 16'd2});
    vecs.push_back('{1'b0, 1'b1, 32'h22,       mk(0, 5'h00, 4'hF, 32'd3),       1'b1, mk(1, 5'h03, 4'h2, 32'h22),       mk(0, 5'h00, 4'hF, 32'd3),       6'd15, 1'b0, 16'd3});
    vecs.push_back('{1'b0, 1'b1, 32'h33,       mk(1, 5'h01, 4'hE, 32'd2),       1'b1, mk(1, 5'h03, 4'h2, 32'h33),       mk(1, 5'h01, 4'hE, 32'd2),       6'd14, 1'b0, 16'd4});
    vecs.push_back('{1'b0, 1'b1, 32'h44,       '0,                              1'b1, mk(1, 5'h03, 4'h2, 32'h44),       '0,                              6'd13, 1'b0, 16'd5});
    vecs.push_back('{1'b0, 1'b1, 32'h55,       '0,                              1'b1, mk(1, 5'h03, 4'h2, 32'h55),       '0,                              6'd12, 1'b0, 16'd6});
    vecs.push_back('{1'b0, 1'b1, 32'h66,       '0,                              1'b1, mk(1, 5'h03, 4'h2, 32'h66),       '0,                              6'd11, 1'b0, 16'd7});
    vecs.push_back('{1'b0, 1'b1, 32'h77,       '0,                              1'b1, mk(1, 5'h03, 4'h2, 32'h77),       '0,                              6'd10, 1'b0, 16'd8});
    vecs.push_back('{1'b0, 1'b1, 32'h88,       cred(32'd2),                     1'b1, mk(1, 5'h03, 4'h2, 32'h88),       '0,                              6'd11, 1'b0, 16'd9});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        '0,                              1'b1, '0,                              '0,                              6'd11, 1'b0, 16'd9});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        cred(32'h141),                   1'b1, '0,                              '0,                              6'd12, 1'b0, 16'd9});

    cfg_addr = 5'h03;
    cfg_port = 4'h2;
    foreach (vecs[i]) begin
      cfg_load      = vecs[i].cfg;
      bus.din_valid = vecs[i].valid;
      bus.din       = vecs[i].data;
      bus.pkt_in    = vecs[i].pin;
      step();
      chk($sformatf("row%0d din_ready", i), bus.din_ready, vecs[i].e_ready);
      chk($sformatf("row%0d pkt_out", i),   bus.pkt_out,   vecs[i].e_pout);
      chk($sformatf("row%0d rx_pkt", i),    bus.rx_pkt,    vecs[i].e_rx);
      chk($sformatf("row%0d credits", i),   credits,       vecs[i].e_cred);
      chk($sformatf("row%0d cred_err", i),  cred_err,      vecs[i].e_err);
      chk($sformatf("row%0d tx_count", i),  tx_count,      vecs[i].e_tx);
    end
    cfg_load      = 1'b0;
    bus.din_valid = 1'b0;
    bus.pkt_in    = '0;

    // Drain all 16 credits, stall, then reopen with a return of 3
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    chk("drain start credits", credits, 16);
    for (int i = 0; i < 16; i++) begin
      bus.din_valid = 1'b1;
      bus.din       = 32'h1000 + i;
      step();
      chk($sformatf("drain%0d pkt_out", i), bus.pkt_out, mk(1, 5'h03, 4'h2, 32'h1000 + i));
      chk($sformatf("drain%0d credits", i), credits, 15 - i);
    end
    chk("drain stall din_ready", bus.din_ready, 0);
    chk("drain tx_count", tx_count, 25);
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("stall%0d pkt_out", i), bus.pkt_out, 0);
      chk($sformatf("stall%0d credits", i), credits, 0);
    end
    bus.pkt_in = cred(32'd3);
    step();
    bus.pkt_in = '0;
    chk("reopen din_ready", bus.din_ready, 1);
    chk("reopen credits", credits, 3);
    chk("reopen pkt_out", bus.pkt_out, 0);
    chk("reopen rx_pkt", bus.rx_pkt, 0);
    sent = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.pkt_out[PKT_W-1]) sent++;
    end
    chk("reopen sent", sent, 3);
    chk("restall credits", credits, 0);
    chk("restall din_ready", bus.din_ready, 0);
    chk("restall tx_count", tx_count, 28);
    bus.din_valid = 1'b0;

    // Reset lands on the cycle after a send and while another is offered
    cfg_addr = 5'h1F;
    cfg_port = 4'h5;
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    chk("relatch din_ready", bus.din_ready, 1);
    bus.din_valid = 1'b1;
    bus.din       = 32'hCAFE0001;
    step();
    chk("relatch pkt_out", bus.pkt_out, mk(1, 5'h1F, 4'h5, 32'hCAFE0001));
    reset   = 1'b1;
    bus.din = 32'hCAFE0002;
    step();
    reset = 1'b0;
    chk("midreset pkt_out",   bus.pkt_out,   0);
    chk("midreset din_ready", bus.din_ready, 0);
    chk("midreset credits",   credits,       16);
    chk("midreset tx_count",  tx_count,      0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("postreset%0d din_ready", i), bus.din_ready, 0);
      chk($sformatf("postreset%0d pkt_out", i),   bus.pkt_out,   0);
    end
    bus.din_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
